// File: rtl/led_pattern_ctrl_if.sv
// Configuration handshake between the pin-level config source and the LED pattern engine.
interface led_pattern_ctrl_if #(
  parameter int N_LEDS = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_mode;
  logic [N_LEDS-1:0] cfg_pattern;
  logic [2:0]        cfg_bright;

  modport master (
    output cfg_valid, cfg_mode, cfg_pattern, cfg_bright,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_pattern, cfg_bright,
    output cfg_ready
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Programmable LED pattern engine: off/static/blink/chase with a tick prescaler and 3-bit PWM dimming.
module led_pattern_ctrl #(
  parameter int N_LEDS  = 8,
  parameter int DIV     = 4096,
  parameter int PRESC_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  led_pattern_ctrl_if.slave   cfg,
  output logic [N_LEDS-1:0]   led_out,
  output logic                tick,
  output logic                busy
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_CHASE  = 2'd3;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(DIV - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_RUN
  } state_t;

  state_t              state;
  logic [PRESC_W-1:0]  presc;
  logic [2:0]          pwm_cnt;
  logic                phase;
  logic [1:0]          mode_reg;
  logic [N_LEDS-1:0]   pattern_reg;
  logic [2:0]          bright_reg;
  logic [1:0]          cap_mode;
  logic [N_LEDS-1:0]   cap_pattern;
  logic [2:0]          cap_bright;
  logic                cfg_ready_r;
  logic                xfer;

  assign cfg.cfg_ready = cfg_ready_r;
  assign xfer          = cfg.cfg_valid & cfg_ready_r;

  function automatic logic [N_LEDS-1:0] rotl1(input logic [N_LEDS-1:0] pat);
    return {pat[N_LEDS-2:0], pat[N_LEDS-1]};
  endfunction

  // PWM gate first, then the blink dark phase; RUN never holds MODE_OFF.
  function automatic logic [N_LEDS-1:0] led_value(
    input logic [1:0]        mode,
    input logic [N_LEDS-1:0] pat,
    input logic              ph,
    input logic [2:0]        cnt,
    input logic [2:0]        bright
  );
    if (cnt > bright) return '0;
    if (mode == MODE_BLINK && ph) return '0;
    return pat;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      led_out     <= '0;
      cfg_ready_r <= 1'b1;
      tick        <= 1'b0;
      busy        <= 1'b0;
      presc       <= '0;
      pwm_cnt     <= '0;
      phase       <= 1'b0;
      pattern_reg <= '0;
      mode_reg    <= MODE_OFF;
      bright_reg  <= '0;
    end else begin
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          led_out <= '0;
          if (xfer) begin
            cap_mode    <= cfg.cfg_mode;
            cap_pattern <= cfg.cfg_pattern;
            cap_bright  <= cfg.cfg_bright;
            cfg_ready_r <= 1'b0;
            state       <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          mode_reg    <= cap_mode;
          pattern_reg <= cap_pattern;
          bright_reg  <= cap_bright;
          presc       <= '0;
          pwm_cnt     <= '0;
          phase       <= 1'b0;
          led_out     <= '0;
          cfg_ready_r <= 1'b1;
          if (cap_mode == MODE_OFF) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end

        ST_RUN: begin
          // A new word wins over any tick action pending on this edge.
          if (xfer) begin
            cap_mode    <= cfg.cfg_mode;
            cap_pattern <= cfg.cfg_pattern;
            cap_bright  <= cfg.cfg_bright;
            cfg_ready_r <= 1'b0;
            busy        <= 1'b0;
            led_out     <= '0;
            state       <= ST_APPLY;
          end else begin
            presc   <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
            tick    <= (presc == PRESC_PRE);
            pwm_cnt <= pwm_cnt + 3'd1;
            if (presc == PRESC_LAST) begin
              if (mode_reg == MODE_BLINK) phase <= ~phase;
              if (mode_reg == MODE_CHASE) pattern_reg <= rotl1(pattern_reg);
            end
            led_out <= led_value(mode_reg, pattern_reg, phase, pwm_cnt, bright_reg);
          end
        end

        default: begin
          state       <= ST_IDLE;
          led_out     <= '0;
          cfg_ready_r <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  logic unused_static;
  assign unused_static = (MODE_STATIC == 2'd1);

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a short prescaler (DIV=4).
module tb_led_pattern_ctrl;
  localparam int N_LEDS  = 8;
  localparam int DIV     = 4;
  localparam int PRESC_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_LEDS-1:0] led_out;
  logic              tick;
  logic              busy;
  int                passed = 0;
  int                total  = 0;

  led_pattern_ctrl_if #(.N_LEDS(N_LEDS)) cfg ();

  led_pattern_ctrl #(.N_LEDS(N_LEDS), .DIV(DIV), .PRESC_W(PRESC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg),
    .led_out (led_out),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] x, input int r);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < r; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  // Leaves the bench just after the transfer edge, with the DUT in APPLY.
  task automatic send(input logic [1:0] m, input logic [7:0] p, input logic [2:0] b);
    cfg.cfg_valid   = 1'b1;
    cfg.cfg_mode    = m;
    cfg.cfg_pattern = p;
    cfg.cfg_bright  = b;
    step();
    cfg.cfg_valid   = 1'b0;
    cfg.cfg_mode    = ~m;
    cfg.cfg_pattern = ~p;
    cfg.cfg_bright  = ~b;
    chk("apply_ready", 32'(cfg.cfg_ready), 32'd0);
    chk("apply_led", 32'(led_out), 32'd0);
    chk("apply_tick", 32'(tick), 32'd0);
  endtask

  initial begin
    int exp_led;
    int exp_tick;

    rst = 1'b1;
    cfg.cfg_valid   = 1'b1;
    cfg.cfg_mode    = 2'd1;
    cfg.cfg_pattern = 8'hFF;
    cfg.cfg_bright  = 3'd7;
    step();
    step();
    rst = 1'b0;
    cfg.cfg_valid = 1'b0;
    chk("rst_led", 32'(led_out), 32'h00);
    chk("rst_ready", 32'(cfg.cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    step();
    step();
    chk("rst_no_apply_ready", 32'(cfg.cfg_ready), 32'd1);
    chk("rst_no_apply_busy", 32'(busy), 32'd0);
    chk("rst_no_apply_led", 32'(led_out), 32'h00);

    // STATIC 0xA5 at full brightness
    send(2'd1, 8'hA5, 3'd7);
    step();
    chk("static_ready_back", 32'(cfg.cfg_ready), 32'd1);
    chk("static_busy", 32'(busy), 32'd1);
    chk("static_led_t1", 32'(led_out), 32'h00);
    for (int n = 2; n <= 101; n++) begin
      step();
      exp_tick = (n % 4 == 0) ? 1 : 0;
      chk("static_led", 32'(led_out), 32'hA5);
      chk("static_tick", 32'(tick), 32'(exp_tick));
    end

    // BLINK 0x0F: 4 cycles lit, 4 dark
    send(2'd2, 8'h0F, 3'd7);
    step();
    for (int n = 2; n <= 25; n++) begin
      step();
      exp_led = (((n - 2) / 4) % 2 == 0) ? 32'h0F : 32'h00;
      chk("blink_led", 32'(led_out), 32'(exp_led));
    end

    // CHASE from 0x80, rotating left once per tick
    send(2'd3, 8'h80, 3'd7);
    step();
    for (int n = 2; n <= 37; n++) begin
      step();
      chk("chase_led", 32'(led_out), 32'(rot8(8'h80, (n - 2) / 4)));
    end
    chk("chase_full_wrap", 32'(led_out), 32'h80);
    step();
    step();
    step();
    chk("collide_tick_high", 32'(tick), 32'd1);

    // New config lands on the tick edge: no rotate, new seed used as-is
    send(2'd3, 8'h11, 3'd7);
    step();
    chk("collide_led_t1", 32'(led_out), 32'h00);
    for (int n = 2; n <= 5; n++) begin
      step();
      chk("collide_led", 32'(led_out), 32'h11);
    end
    step();
    chk("collide_rot", 32'(led_out), 32'h22);

    // OFF
    send(2'd0, 8'hFF, 3'd7);
    chk("off_apply_busy", 32'(busy), 32'd0);
    step();
    chk("off_busy", 32'(busy), 32'd0);
    chk("off_ready", 32'(cfg.cfg_ready), 32'd1);
    for (int n = 2; n <= 11; n++) begin
      step();
      chk("off_led", 32'(led_out), 32'h00);
      chk("off_tick", 32'(tick), 32'd0);
    end

    // PWM bright=2: on for pwm_cnt 0..2
    send(2'd1, 8'hFF, 3'd2);
    step();
    for (int n = 2; n <= 25; n++) begin
      step();
      exp_led = (((n - 2) % 8) <= 2) ? 32'hFF : 32'h00;
      chk("pwm2_led", 32'(led_out), 32'(exp_led));
    end

    // PWM bright=0: 1 of 8
    send(2'd1, 8'hFF, 3'd0);
    step();
    for (int n = 2; n <= 25; n++) begin
      step();
      exp_led = (((n - 2) % 8) == 0) ? 32'hFF : 32'h00;
      chk("pwm0_led", 32'(led_out), 32'(exp_led));
    end

    // Reset while running
    send(2'd1, 8'h3C, 3'd7);
    step();
    step();
    chk("mid_run_led", 32'(led_out), 32'h3C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_led", 32'(led_out), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cfg.cfg_ready), 32'd1);
    step();
    chk("mid_rst_led_hold", 32'(led_out), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Sequencer for the chip's LED output bank: accepts a configuration word over a valid/ready handshake and drives N_LEDS LED lines.
- Pattern modes: off, static, blink, chase, plus global PWM brightness.
- Sits between the top-level input pins (config source) and uo_out. Replaces hard-wired LED constants with a programmable, timed pattern engine.

Parameters:
N_LEDS, 8, number of LED outputs / pattern width
DIV, 4096, prescaler period in clk cycles per pattern tick (legal range DIV >= 2)
PRESC_W, 16, prescaler counter width (must satisfy 2^PRESC_W >= DIV)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cfg_valid  input  1  config word present
cfg_ready  output  1  block can accept config this cycle
cfg_mode  input  2  0=OFF 1=STATIC 2=BLINK 3=CHASE
cfg_pattern  input  N_LEDS  LED pattern / chase seed
cfg_bright  input  3  PWM brightness 0..7
led_out  output  N_LEDS  registered LED drive
tick  output  1  one-cycle pulse at each pattern tick (RUN only)
busy  output  1  high in RUN state

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, led_out=0, cfg_ready=1, tick=0, busy=0, prescaler=0, pwm_cnt=0, phase=0, pattern_reg=0, mode_reg=OFF, bright_reg=0. rst overrides all other inputs, including a handshake in the same cycle.
- Handshake: transfer occurs when cfg_valid & cfg_ready at a rising edge. cfg_valid while cfg_ready=0 is ignored; the source holds it.
- FSM states:
  - IDLE: cfg_ready=1, led_out=0. Transfer -> APPLY.
  - APPLY: one cycle; cfg_ready=0. Loads mode_reg/pattern_reg/bright_reg from the captured word and clears prescaler, pwm_cnt and phase. Next state: IDLE if mode=OFF, else RUN.
  - RUN: cfg_ready=1, busy=1. Transfer -> APPLY, so reconfiguration is allowed at any time.
- Capture: the config word is registered at the transfer edge, so the inputs may change immediately after.
- Prescaler (RUN only): counts 0..DIV-1 and wraps. tick=1 in the cycle the count equals DIV-1. The first tick occurs DIV cycles after entering RUN.
- Per-tick actions:
  - BLINK: phase toggles.
  - CHASE: pattern_reg rotates left by 1 (MSB wraps to bit 0).
  - STATIC: no change.
- PWM:
  - pwm_cnt is a 3-bit free-running counter in RUN, wrapping 7->0.
  - Enable when pwm_cnt <= bright_reg.
  - bright=7 gives always on; bright=0 gives 1/8 duty.
- led_out (registered) in RUN: pwm_en ? (BLINK&phase ? 0 : pattern_reg) : 0. In IDLE/APPLY: led_out=0.
- Latency:
  - Transfer at edge T -> APPLY during T..T+1.
  - RUN from T+1, with first new led_out value after edge T+2.
- Boundary cases:
  - A CHASE seed of 0 stays 0.
  - A CHASE seed of all-ones stays all-ones.
  - A transfer in the same cycle as tick: the tick action is discarded and the new config is applied.
  - Reset mid-RUN returns to the IDLE state with led_out=0 on the next edge.

Test Plan:
- Reset: assert rst 2 cycles with cfg_valid=1 -> led_out=0x00, cfg_ready=1, busy=0; no APPLY entered.
- STATIC: DIV=4, send mode=1 pattern=0xA5 bright=7 -> cfg_ready low exactly 1 cycle, led_out=0xA5 from 2 cycles after transfer and stable for 100 cycles, tick every 4 cycles.
- BLINK: DIV=4, mode=2 pattern=0x0F bright=7 -> led_out alternates 0x0F/0x00, changing one cycle after each tick pulse.
- CHASE wrap: DIV=4, mode=3 pattern=0x80 bright=7 -> led_out sequence 0x80,0x01,0x02,...,0x80 after 8 ticks.
- PWM: mode=1 pattern=0xFF bright=2 -> led_out=0xFF for 3 of every 8 cycles, 0x00 for 5; bright=0 gives 1 of 8.
- Reconfig collision and off: send a new config in the cycle tick=1 during CHASE -> no rotate, new pattern applied. Then send mode=0 -> IDLE, led_out=0x00, busy=0, tick stays 0.
